nfifo_vc: RTL and testbench
===========================

NFIFO_VC -- requirements
Module: nfifo_vc

Interface
REQ-001 The module SHALL have parameter width, default 32, meaning data bits per entry.
REQ-002 The module SHALL have parameter depth, default 4, meaning entries per channel; power of two, >= 2.
REQ-003 The module SHALL have parameter vc_num, default 2, meaning number of independent channels; >= 2.
REQ-004 Port list SHALL be exactly, in this order:
- clk_i  input  1  single clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- write_i  input  1  write request.
- wvc_i  input  $clog2(vc_num)  write channel select.
- data_i  input  width  write data.
- read_i  input  1  read request.
- rvc_i  input  $clog2(vc_num)  read channel select.
- data_o  output  width  registered read data.
- valid_o  output  1  data_o holds a freshly popped entry.
- empty_o  output  vc_num  per-channel empty, bit i = channel i.
- full_o  output  vc_num  per-channel full, bit i = channel i.
- ovf_o  output  1  sticky overflow flag.
- udf_o  output  1  sticky underflow flag.

Function
REQ-005 Each channel SHALL be an independent FIFO of depth entries with its own read pointer, write pointer and occupancy counter (0..depth, $clog2(depth)+1 bits).
REQ-006 A write SHALL be accepted iff write_i=1 and full_o[wvc_i]=0; data_i is stored at that channel's tail at the edge.
REQ-007 A read SHALL be accepted iff read_i=1 and empty_o[rvc_i]=0; that channel's head is popped at the edge.
REQ-008 Rejected writes/reads SHALL change no pointer, counter, storage, data_o or valid_o.
REQ-009 On an accepted read, data_o SHALL load the popped entry at the same edge; valid_o SHALL be 1 for exactly the following cycle, else 0; data_o holds its last value when valid_o=0.
REQ-010 Read latency SHALL be one cycle; no fall-through: an entry written at edge N is readable no earlier than edge N+1.
REQ-011 empty_o[i] SHALL be 1 iff count[i]=0; full_o[i] SHALL be 1 iff count[i]=depth; both derive from registered state only.
REQ-012 Acceptance SHALL use pre-edge state: write to a full channel with simultaneous read of that channel rejects the write, accepts the read (count depth-1).
REQ-013 Write and read of the same empty channel in one cycle SHALL accept the write only (count 1, valid_o stays 0).
REQ-014 Simultaneous accepted write and read of the same non-empty, non-full channel SHALL leave its count unchanged.
REQ-015 Accesses to different channels in one cycle SHALL proceed independently.
REQ-016 Pointers SHALL wrap modulo depth; FIFO order per channel SHALL be preserved across wrap.
REQ-017 wvc_i/rvc_i values >= vc_num SHALL be treated as rejected accesses.

Reset
REQ-018 While rst_i=1, all pointers and counters SHALL be 0, data_o=0, valid_o=0, ovf_o=0, udf_o=0, so empty_o all ones, full_o all zeros.
REQ-019 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-020 Storage array contents SHALL need no reset; unread stale entries are never visible.

Configuration
REQ-021 With macro NFIFO_VC_ERR_EN defined, ovf_o SHALL set on any write_i=1 to a full channel, udf_o on any read_i=1 to an empty channel; both sticky until reset.
REQ-022 Without NFIFO_VC_ERR_EN, ovf_o and udf_o SHALL be tied to 0 and no flag logic SHALL be generated.

Verification
REQ-023 Reset, then write 0xA1,0xA2 to vc0 and 0xB1 to vc1, read vc1,vc0,vc0 -> data_o 0xB1,0xA1,0xA2, valid_o 1 each following cycle.
REQ-024 depth=4: write 5 entries to vc0 -> full_o[0]=1 after 4th, 5th dropped; with ERR_EN ovf_o=1 and stays 1.
REQ-025 vc0 full, write 0x55 and read vc0 same cycle -> read accepted, write rejected, full_o[0]=0, count 3.
REQ-026 vc1 empty, write 0x77 and read vc1 same cycle -> valid_o=0 next cycle, empty_o[1]=0; read next cycle -> data_o=0x77.
REQ-027 Push/pop 10 entries through vc0 (depth=4) -> order 0..9 preserved across wrap; read empty vc0 -> valid_o=0, udf_o=1 with ERR_EN, 0 without.
REQ-028 Assert rst_i between clock edges with vc0 holding 3 entries -> empty_o=all ones, valid_o=0, data_o=0 immediately.

Source files
------------

// File: rtl/nfifo_vc.sv
// Multi-channel FIFO: vc_num independent FIFOs sharing one storage array, with a registered read port.
// Optional sticky overflow/underflow flags are enabled by defining NFIFO_VC_ERR_EN.
module nfifo_vc #(
  parameter int width  = 32,
  parameter int depth  = 4,
  parameter int vc_num = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      write_i,
  input  logic [$clog2(vc_num)-1:0] wvc_i,
  input  logic [width-1:0]          data_i,
  input  logic                      read_i,
  input  logic [$clog2(vc_num)-1:0] rvc_i,
  output logic [width-1:0]          data_o,
  output logic                      valid_o,
  output logic [vc_num-1:0]         empty_o,
  output logic [vc_num-1:0]         full_o,
  output logic                      ovf_o,
  output logic                      udf_o
);

  localparam int PW  = $clog2(depth);
  localparam int CW  = PW + 1;
  localparam int VCW = $clog2(vc_num);

  logic [width-1:0]  mem    [vc_num][depth];
  logic [PW-1:0]     wr_ptr [vc_num];
  logic [PW-1:0]     rd_ptr [vc_num];
  logic [CW-1:0]     count  [vc_num];
  logic [vc_num-1:0] wr_en;
  logic [vc_num-1:0] rd_en;
  logic              wvc_ok;
  logic              rvc_ok;

  // Channel selects beyond vc_num address nothing and are therefore rejected.
  assign wvc_ok = ({1'b0, wvc_i} < (VCW+1)'(vc_num));
  assign rvc_ok = ({1'b0, rvc_i} < (VCW+1)'(vc_num));

  generate
    for (genvar gi = 0; gi < vc_num; gi++) begin : g_chan
      assign empty_o[gi] = (count[gi] == '0);
      assign full_o[gi]  = (count[gi] == CW'(depth));
      assign wr_en[gi]   = write_i && wvc_ok && (wvc_i == VCW'(gi)) && !full_o[gi];
      assign rd_en[gi]   = read_i && rvc_ok && (rvc_i == VCW'(gi)) && !empty_o[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < vc_num; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      for (int i = 0; i < vc_num; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_en[i] && !rd_en[i])
          count[i] <= count[i] + 1'b1;
        else if (!wr_en[i] && rd_en[i])
          count[i] <= count[i] - 1'b1;
      end
      valid_o <= |rd_en;
      if (|rd_en) data_o <= mem[rvc_i][rd_ptr[rvc_i]];
    end
  end

  // Storage is never reset: zeroed counters keep stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (|wr_en) mem[wvc_i][wr_ptr[wvc_i]] <= data_i;
  end

`ifdef NFIFO_VC_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (write_i && wvc_ok && full_o[wvc_i])  ovf_o <= 1'b1;
      if (read_i && rvc_ok && empty_o[rvc_i])  udf_o <= 1'b1;
    end
  end
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_nfifo_vc.sv
// Directed self-checking bench for nfifo_vc at default parameters (width 32, depth 4, vc_num 2).
module tb_nfifo_vc;

`ifdef NFIFO_VC_ERR_EN
  localparam logic [31:0] ERR = 32'd1;
`else
  localparam logic [31:0] ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write = 1'b0;
  logic [0:0]  wvc = '0;
  logic [31:0] data_in = '0;
  logic        read = 1'b0;
  logic [0:0]  rvc = '0;
  logic [31:0] data_out;
  logic        valid;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic        ovf;
  logic        udf;

  int n_checks = 0;
  int n_fail   = 0;

  nfifo_vc dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .write_i(write),
    .wvc_i  (wvc),
    .data_i (data_in),
    .read_i (read),
    .rvc_i  (rvc),
    .data_o (data_out),
    .valid_o(valid),
    .empty_o(empty),
    .full_o (full),
    .ovf_o  (ovf),
    .udf_o  (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic [0:0] wv, input logic [31:0] wd,
                     input logic r, input logic [0:0] rv);
    write = w; wvc = wv; data_in = wd; read = r; rvc = rv;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_data",  data_out,   32'h0);
    chk("rst_ovf",   32'(ovf),   32'h0);
    chk("rst_udf",   32'(udf),   32'h0);
    #5 rst = 1'b0;

    // Basic ordering across two channels
    cyc(1, 0, 32'hA1, 0, 0);
    cyc(1, 0, 32'hA2, 0, 0);
    cyc(1, 1, 32'hB1, 0, 0);
    chk("wr_empty", 32'(empty), 32'h0);
    cyc(0, 0, 0, 1, 1);
    chk("rd_b1", data_out, 32'hB1);
    chk("rd_b1_v", 32'(valid), 32'h1);
    cyc(0, 0, 0, 1, 0);
    chk("rd_a1", data_out, 32'hA1);
    chk("rd_a1_v", 32'(valid), 32'h1);
    cyc(0, 0, 0, 1, 0);
    chk("rd_a2", data_out, 32'hA2);
    chk("rd_a2_v", 32'(valid), 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("idle_v", 32'(valid), 32'h0);
    chk("idle_hold", data_out, 32'hA2);
    chk("idle_empty", 32'(empty), 32'h3);

    // Fill vc0, fifth write dropped
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 32'(i), 0, 0);
      if (i == 3) chk("full_at3", 32'(full), 32'h0);
      if (i == 4) chk("full_at4", 32'(full), 32'h1);
    end
    chk("full_at5", 32'(full), 32'h1);
    chk("ovf_set", 32'(ovf), ERR);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", 32'(ovf), ERR);
    chk("udf_clear", 32'(udf), 32'h0);

    // Write to full with simultaneous read: read wins, count 3
    cyc(1, 0, 32'h55, 1, 0);
    chk("fr_data", data_out, 32'h1);
    chk("fr_valid", 32'(valid), 32'h1);
    chk("fr_full", 32'(full), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("fr_drain", data_out, 32'(i));
    end
    chk("fr_empty", 32'(empty), 32'h3);

    // Write and read of same empty channel: write only
    cyc(1, 1, 32'h77, 1, 1);
    chk("we_valid", 32'(valid), 32'h0);
    chk("we_empty", 32'(empty), 32'h1);
    chk("we_udf", 32'(udf), ERR);
    cyc(0, 0, 0, 1, 1);
    chk("we_data", data_out, 32'h77);
    chk("we_valid2", 32'(valid), 32'h1);
    chk("we_empty2", 32'(empty), 32'h3);

    // Streaming 0..9 through vc0 across pointer wrap, count held at 1
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 32'(i), i > 0, 0);
      if (i > 0) chk("wrap_data", data_out, 32'(i - 1));
      chk("wrap_empty", 32'(empty), 32'h2);
    end
    cyc(0, 0, 0, 1, 0);
    chk("wrap_last", data_out, 32'h9);
    chk("wrap_drain", 32'(empty), 32'h3);
    cyc(0, 0, 0, 1, 0);
    chk("ue_valid", 32'(valid), 32'h0);
    chk("ue_hold", data_out, 32'h9);
    chk("ue_udf", 32'(udf), ERR);

    // Independent channels in one cycle
    cyc(1, 1, 32'hC3, 0, 0);
    cyc(1, 0, 32'h10, 1, 1);
    chk("ind_data", data_out, 32'hC3);
    chk("ind_valid", 32'(valid), 32'h1);
    chk("ind_empty", 32'(empty), 32'h2);

    // Asynchronous reset with three entries held in vc0
    cyc(1, 0, 32'h11, 0, 0);
    cyc(1, 0, 32'h12, 0, 0);
    cyc(1, 0, 32'h13, 1, 0);
    chk("pre_data", data_out, 32'h10);
    chk("pre_valid", 32'(valid), 32'h1);
    chk("pre_empty", 32'(empty), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("ar_empty", 32'(empty), 32'h3);
    chk("ar_full",  32'(full),  32'h0);
    chk("ar_valid", 32'(valid), 32'h0);
    chk("ar_data",  data_out,   32'h0);
    chk("ar_ovf",   32'(ovf),   32'h0);
    chk("ar_udf",   32'(udf),   32'h0);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 1, 0);
    chk("post_valid", 32'(valid), 32'h0);
    chk("post_data", data_out, 32'h0);
    chk("post_empty", 32'(empty), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
